// File: rtl/dot_seq.sv
// Read-side sequencer: walks read ports A/B in lockstep, accumulates element products,
// returns one scalar over valid/ready. Define DOT_SEQ_SIGNED_EN for two's-complement operands.
module dot_seq #(
  parameter int DATA_WIDTH  = 8,
  parameter int VETOR_WIDTH = 4,
  parameter int DEPTH       = VETOR_WIDTH*DATA_WIDTH,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int ACC_WIDTH   = 2*DATA_WIDTH+ADDR_WIDTH+1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_done,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  rd_en_a,
  output logic                  rd_en_b,
  output logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [ADDR_WIDTH-1:0] rd_addr_b,
  input  logic [DATA_WIDTH-1:0] dout_a,
  input  logic [DATA_WIDTH-1:0] dout_b,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy,
  output logic                  err
);

  localparam int PW = 2*DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_DRAIN, S_DONE} state_e;
  state_e state_q, state_d;

  logic                  loaded_q, err_q, rd_en_q;
  logic [ADDR_WIDTH-1:0] base_q, addr_q;
  logic [ADDR_WIDTH:0]   len_q, cnt_q, len_clamp;
  logic [1:0]            vld_pipe_q;   // [0]: dout valid, [1]: prod_q valid
  logic [PW-1:0]         prod_q, mult;
  logic [ACC_WIDTH-1:0]  acc_q, prod_ext;
  logic                  start_acc;

  assign len_clamp = (len > DEPTH_L) ? DEPTH_L : len;
  assign start_acc = (state_q == S_IDLE) && start;

`ifdef DOT_SEQ_SIGNED_EN
  assign mult     = $signed({{DATA_WIDTH{dout_a[DATA_WIDTH-1]}}, dout_a}) *
                    $signed({{DATA_WIDTH{dout_b[DATA_WIDTH-1]}}, dout_b});
  assign prod_ext = {{(ACC_WIDTH-PW){prod_q[PW-1]}}, prod_q};
`else
  assign mult     = {{DATA_WIDTH{1'b0}}, dout_a} * {{DATA_WIDTH{1'b0}}, dout_b};
  assign prod_ext = {{(ACC_WIDTH-PW){1'b0}}, prod_q};
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) begin
                 if (len_clamp == '0) state_d = S_DONE;
                 else if (loaded_q)   state_d = S_READ;
                 else                 state_d = S_WAIT;
               end
      S_WAIT:  if (loaded_q || mem_done) state_d = S_READ;
      S_READ:  if (cnt_q == len_q) state_d = S_DRAIN;
      // last product is formed once dout stops being valid; acc absorbs it on this edge
      S_DRAIN: if (!vld_pipe_q[0]) state_d = S_DONE;
      S_DONE:  if (result_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != S_IDLE);
    result_valid = (state_q == S_DONE);
    rd_en_a      = rd_en_q;
    rd_en_b      = rd_en_q;
    rd_addr_a    = addr_q;
    rd_addr_b    = addr_q;
    result       = acc_q;
    err          = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loaded_q   <= 1'b0;
      err_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      base_q     <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      vld_pipe_q <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
    end else begin
      loaded_q <= loaded_q | mem_done;
      if (start_acc) begin
        base_q <= base_addr;
        len_q  <= len_clamp;
        err_q  <= 1'b0;
      end else if (mem_done && (state_q == S_READ || state_q == S_DRAIN)) begin
        err_q <= 1'b1;
      end
      // first read issues on the same edge that enters READ
      rd_en_q <= (state_d == S_READ);
      if (state_d == S_READ) begin
        if (state_q != S_READ) begin
          addr_q <= (state_q == S_IDLE) ? base_addr : base_q;
          cnt_q  <= (ADDR_WIDTH+1)'(1);
        end else begin
          addr_q <= addr_q + 1'b1;
          cnt_q  <= cnt_q + 1'b1;
        end
      end
      vld_pipe_q <= {vld_pipe_q[0], rd_en_q};
      if (vld_pipe_q[0]) prod_q <= mult;
      if (start_acc)          acc_q <= '0;
      else if (vld_pipe_q[1]) acc_q <= acc_q + prod_ext;
    end
  end

endmodule

// File: tb/tb_dot_seq.sv
// Randomized self-checking bench for dot_seq: memory model, address/latency/result
// reference computed from element sums, plus directed wrap/clamp/wait/error/reset cases.
module tb_dot_seq;
  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int ACCW  = 2*DW+AW+1;

  logic            clk = 0, rst = 1, mem_done = 0, start = 0, result_ready = 0;
  logic [AW-1:0]   base_addr = '0;
  logic [AW:0]     len = '0;
  logic            rd_en_a, rd_en_b, result_valid, busy, err;
  logic [AW-1:0]   rd_addr_a, rd_addr_b;
  logic [DW-1:0]   dout_a = '0, dout_b = '0;
  logic [ACCW-1:0] result;

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  int            rd_q[$];
  int            pair_bad = 0;
  int            checks = 0, errors = 0;
  bit            loaded_m = 0;

  dot_seq dut (
    .clk(clk), .rst(rst), .mem_done(mem_done), .start(start),
    .base_addr(base_addr), .len(len),
    .rd_en_a(rd_en_a), .rd_en_b(rd_en_b), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .dout_a(dout_a), .dout_b(dout_b), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en_a) dout_a <= mem_a[rd_addr_a];
    if (rd_en_b) dout_b <= mem_b[rd_addr_b];
  end

  always @(negedge clk) begin
    if (rd_en_a) rd_q.push_back(int'(rd_addr_a));
    if (rd_en_a !== rd_en_b || rd_addr_a !== rd_addr_b) pair_bad++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ACCW-1:0] model_sum(input int base, input int n);
    longint acc = 0;
    for (int i = 0; i < n; i++) begin
      int idx = (base + i) % DEPTH;
`ifdef DOT_SEQ_SIGNED_EN
      byte sa = mem_a[idx];
      byte sb = mem_b[idx];
      acc += longint'(sa) * longint'(sb);
`else
      acc += longint'(mem_a[idx]) * longint'(mem_b[idx]);
`endif
    end
    return acc[ACCW-1:0];
  endfunction

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = DW'($urandom);
      mem_b[i] = DW'($urandom);
    end
  endtask

  task automatic pulse_mem_done();
    @(negedge clk); mem_done = 1;
    @(negedge clk); mem_done = 0;
    loaded_m = 1;
  endtask

  // One full transaction: start, optional wait-for-load, latency, result, backpressure, handshake.
  task automatic run(input int base, input int ln, input int hold, input bit md_mid,
                     output logic [ACCW-1:0] got);
    int n = (ln > DEPTH) ? DEPTH : ln;
    int k;
    logic [ACCW-1:0] exp_sum = model_sum(base, n);
    logic [ACCW-1:0] held;
    @(negedge clk);
    start = 1; base_addr = AW'(base); len = (AW+1)'(ln);
    rd_q.delete(); pair_bad = 0;
    @(posedge clk);
    @(negedge clk); start = 0;
    chk("busy_after_start", busy, 1);
    if (n != 0 && !loaded_m) begin
      repeat (10) @(negedge clk);
      chk("wait_no_reads", rd_q.size(), 0);
      chk("wait_busy", busy, 1);
      mem_done = 1;
      @(posedge clk);
      @(negedge clk); mem_done = 0; loaded_m = 1;
      chk("wait_rd_en", rd_en_a, 1);
    end
    k = 0;
    while (!result_valid && k < 200) begin
      mem_done = md_mid && (k == 1);
      @(negedge clk);
      k++;
    end
    mem_done = 0;
    chk("latency", k, (n == 0) ? 0 : n + 2);
    chk("result", result, exp_sum);
    chk("err", err, md_mid);
    held = result;
    for (int i = 0; i < hold; i++) begin
      start = (i == 0); len = '0; base_addr = AW'($urandom);
      @(posedge clk);
      @(negedge clk); start = 0;
      chk("hold_valid", result_valid, 1);
      chk("hold_result", result, held);
    end
    result_ready = 1;
    @(posedge clk);
    @(negedge clk); result_ready = 0;
    chk("hs_valid", result_valid, 0);
    chk("hs_busy", busy, 0);
    chk("nreads", rd_q.size(), n);
    for (int i = 0; i < n; i++)
      if (i < rd_q.size()) chk("addr", rd_q[i], (base + i) % DEPTH);
    chk("pair", pair_bad, 0);
    got = held;
  endtask

  initial begin
    logic [ACCW-1:0] r;
    repeat (3) @(negedge clk);
    chk("rst_rd_en", rd_en_a, 0);
    chk("rst_addr", rd_addr_a, 0);
    chk("rst_result", result, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 0;

    // basic
    fill_random();
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = DW'(i + 1);
      mem_b[i] = DW'(i + 5);
    end
    pulse_mem_done();
    run(0, 4, 0, 0, r);
    chk("basic70", r, 70);

    // wrap, clamp, len=0 with backpressure
    run(30, 4, 2, 0, r);
    fill_random();
    run(int'($urandom_range(0, 31)), 40, 0, 0, r);
    run(5, 0, 5, 0, r);
    chk("len0_zero", r, 0);

    // error then cleared by next start
    run(3, 12, 0, 1, r);
    run(7, 6, 1, 0, r);

    // reset mid-READ
    @(negedge clk); start = 1; base_addr = 2; len = 20;
    @(posedge clk);
    @(negedge clk); start = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(posedge clk);
    @(negedge clk); rst = 0; loaded_m = 0;
    chk("rstmid_rd_en", rd_en_a, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_valid", result_valid, 0);
    chk("rstmid_result", result, 0);

    // start without load -> waits for mem_done
    fill_random();
    run(int'($urandom_range(0, 31)), int'($urandom_range(1, 32)), 3, 0, r);

    // all -1 x 2 over full depth
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = 8'hFF;
      mem_b[i] = 8'h02;
    end
    run(0, 32, 0, 0, r);
`ifdef DOT_SEQ_SIGNED_EN
    chk("signed_m64", r, ACCW'(-64));
`else
    chk("unsigned_16320", r, 16320);
`endif

    // random sweep
    for (int t = 0; t < 8; t++) begin
      fill_random();
      run(int'($urandom_range(0, 31)), int'($urandom_range(0, 45)),
          int'($urandom_range(0, 3)), 0, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
